// File: rtl/sap_core_p.sv
// sap_core_p: parametrised single-bus accumulator CPU with a loadable program/data RAM.
// Fetch/execute runs F1 -> F2 -> E1 [-> E2] -> F1. ld_en forces LOAD from any state, and
// HALT is left only through LOAD or reset.
module sap_core_p #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr_,
  input  logic              ld_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] sap_out,
  output logic              out_valid,
  output logic              halted,
  output logic              zf,
  output logic              cf
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  // The IR keeps only the opcode and operand fields. Bits between them are never decoded.
  localparam int unsigned IrW   = 4 + ADDR_W;

  localparam logic [3:0] OpLda = 4'd0;
  localparam logic [3:0] OpAdd = 4'd1;
  localparam logic [3:0] OpSub = 4'd2;
  localparam logic [3:0] OpSta = 4'd3;
  localparam logic [3:0] OpJmp = 4'd4;
  localparam logic [3:0] OpJz  = 4'd5;
  localparam logic [3:0] OpJc  = 4'd6;
  localparam logic [3:0] OpOut = 4'd14;
  localparam logic [3:0] OpHlt = 4'd15;

  localparam logic [ADDR_W-1:0] PcOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  if (DATA_W < 4 + ADDR_W) begin : gen_bad_width
    $error("sap_core_p: DATA_W must be at least 4 + ADDR_W");
  end

  typedef enum logic [2:0] {
    StLoad,
    StF1,
    StF2,
    StE1,
    StE2,
    StHalt
  } state_e;

  // Architectural state
  state_e              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_mar;
  logic [IrW-1:0]      r_ir;
  logic [DATA_W-1:0]   r_a;
  logic                r_zf;
  logic                r_cf;
  logic [DATA_W-1:0]   r_out;
  logic                r_out_valid;
  logic                r_halted;
  logic [DATA_W-1:0]   r_mem [Depth];

  // Next-state values
  state_e              w_state_d;
  logic [ADDR_W-1:0]   w_pc_d;
  logic [ADDR_W-1:0]   w_mar_d;
  logic [IrW-1:0]      w_ir_d;
  logic [DATA_W-1:0]   w_a_d;
  logic                w_zf_d;
  logic                w_cf_d;
  logic [DATA_W-1:0]   w_out_d;
  logic                w_out_valid_d;

  // Memory write port
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_waddr;
  logic [DATA_W-1:0]   w_mem_wdata;

  // Decode and datapath
  logic [DATA_W-1:0]   w_mem_rd;
  logic [3:0]          w_opcode;
  logic [ADDR_W-1:0]   w_operand;
  logic                w_is_mem_op;
  logic                w_take_jump;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;

  assign w_mem_rd  = r_mem[r_mar];
  assign w_opcode  = r_ir[IrW-1 -: 4];
  assign w_operand = r_ir[ADDR_W-1:0];

  // Instruction class decode from the latched IR.
  always_comb begin
    w_is_mem_op = 1'b0;
    w_take_jump = 1'b0;
    unique case (w_opcode)
      OpLda, OpAdd, OpSub, OpSta: w_is_mem_op = 1'b1;
      OpJmp:                      w_take_jump = 1'b1;
      OpJz:                       w_take_jump = r_zf;
      OpJc:                       w_take_jump = r_cf;
      default:                    ;
    endcase
  end

  // Extra top bit holds carry-out for ADD, and the borrow for SUB.
  always_comb begin
    w_sum  = {1'b0, r_a} + {1'b0, w_mem_rd};
    w_diff = {1'b0, r_a} - {1'b0, w_mem_rd};
  end

  // Control FSM next state. ld_en overrides everything, including HALT.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StLoad: w_state_d = StF1;
      StF1:   w_state_d = StF2;
      StF2:   w_state_d = StE1;
      StE1: begin
        if (w_is_mem_op) begin
          w_state_d = StE2;
        end else if (w_opcode == OpHlt) begin
          w_state_d = StHalt;
        end else begin
          w_state_d = StF1;
        end
      end
      StE2:    w_state_d = StF1;
      StHalt:  w_state_d = StHalt;
      default: w_state_d = StF1;
    endcase
    if (ld_en) begin
      w_state_d = StLoad;
    end
  end

  // Datapath next state. An ld_en edge aborts the instruction and clears only PC and MAR.
  always_comb begin
    w_pc_d        = r_pc;
    w_mar_d       = r_mar;
    w_ir_d        = r_ir;
    w_a_d         = r_a;
    w_zf_d        = r_zf;
    w_cf_d        = r_cf;
    w_out_d       = r_out;
    w_out_valid_d = 1'b0;
    if (ld_en) begin
      w_pc_d  = '0;
      w_mar_d = '0;
    end else begin
      unique case (r_state)
        StF1: w_mar_d = r_pc;
        StF2: begin
          w_ir_d = {w_mem_rd[DATA_W-1 -: 4], w_mem_rd[ADDR_W-1:0]};
          w_pc_d = r_pc + PcOne;
        end
        StE1: begin
          if (w_is_mem_op) begin
            w_mar_d = w_operand;
          end else if (w_take_jump) begin
            w_pc_d = w_operand;
          end else if (w_opcode == OpOut) begin
            w_out_d       = r_a;
            w_out_valid_d = 1'b1;
          end
        end
        StE2: begin
          unique case (w_opcode)
            OpLda: w_a_d = w_mem_rd;
            OpAdd: begin
              w_a_d  = w_sum[DATA_W-1:0];
              w_cf_d = w_sum[DATA_W];
              w_zf_d = (w_sum[DATA_W-1:0] == '0);
            end
            OpSub: begin
              w_a_d  = w_diff[DATA_W-1:0];
              w_cf_d = ~w_diff[DATA_W];
              w_zf_d = (w_diff[DATA_W-1:0] == '0);
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Memory write port: loader in LOAD, otherwise STA in E2 (the store wins no arbitration
  // because the two sources never coexist in one state).
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = prog_addr;
    w_mem_wdata = prog_data;
    if (r_state == StLoad) begin
      w_mem_we = prog_we;
    end else if (r_state == StE2 && !ld_en && w_opcode == OpSta) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_mar;
      w_mem_wdata = r_a;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      r_state     <= StF1;
      r_pc        <= '0;
      r_mar       <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_zf        <= 1'b0;
      r_cf        <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pc        <= w_pc_d;
      r_mar       <= w_mar_d;
      r_ir        <= w_ir_d;
      r_a         <= w_a_d;
      r_zf        <= w_zf_d;
      r_cf        <= w_cf_d;
      r_out       <= w_out_d;
      r_out_valid <= w_out_valid_d;
      r_halted    <= (w_state_d == StHalt);
    end
  end

  // Program/data RAM: synchronous write, contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  assign sap_out   = r_out;
  assign out_valid = r_out_valid;
  assign halted    = r_halted;
  assign zf        = r_zf;
  assign cf        = r_cf;

endmodule

// File: doc/sap_core_p.md
# sap_core_p

Parametrised single-bus accumulator CPU core: the next generation of the team's SAP-1 top level. It generalises data and address width and replaces the fixed ROM with a loadable single-port program/data RAM. It adds a store instruction, zero/carry flags, conditional and unconditional jumps, a halt state and an OUT strobe. It sits at the top of a SAP micro-benchmark and is driven only by a clock, a reset and a program-load port.

## Interface
- DATA_W, 8: data/instruction word width; must satisfy DATA_W >= 4 + ADDR_W.
- ADDR_W, 4: memory address width; depth = 2^ADDR_W words.
- clk  in  1  system clock, all state on rising edge.
- clr_  in  1  asynchronous, active-low reset.
- ld_en  in  1  program-load mode; core held in LOAD while high.
- prog_we  in  1  memory write strobe, honoured only in LOAD.
- prog_addr  in  ADDR_W  load write address.
- prog_data  in  DATA_W  load write data.
- sap_out  out  DATA_W  output register.
- out_valid  out  1  one-cycle pulse when sap_out is updated.
- halted  out  1  high while in HALT.
- zf, cf  out  1  zero and carry flags.

## Operation
- Instruction word: opcode = bits [DATA_W-1:DATA_W-4], operand = bits [ADDR_W-1:0]; any other bits are ignored.
- Opcodes:
  - 0 LDA: A <= M[op].
  - 1 ADD: A <= A+M[op].
  - 2 SUB: A <= A-M[op].
  - 3 STA: M[op] <= A.
  - 4 JMP: PC <= op.
  - 5 JZ: jump if zf.
  - 6 JC: jump if cf.
  - 14 OUT: sap_out <= A.
  - 15 HLT.
  - All others are NOP.
- States: LOAD, F1, F2, E1, E2, HALT.
  - F1: MAR <= PC.
  - F2: IR <= M[MAR]; PC <= PC+1, wrapping from 2^ADDR_W-1 to 0.
  - E1 for LDA/ADD/SUB/STA: MAR <= operand, then go to E2.
  - E1 for JMP, or JZ/JC with the condition true: PC <= operand, then F1. Condition false: F1 with PC unchanged.
  - E1 for OUT: sap_out <= A, out_valid pulses, then F1.
  - E1 for NOP: go to F1.
  - E1 for HLT: go to HALT.
  - E2: perform the LDA/ADD/SUB/STA data action, then F1.
- Memory: combinational read, synchronous write. Writes come from prog_we in LOAD or from STA in E2. Contents are not cleared by reset.
- Arithmetic:
  - ADD and SUB are DATA_W bits modulo 2^DATA_W.
  - ADD: cf = carry-out.
  - SUB: cf = 1 when A >= M (no borrow).
  - zf = (result == 0).
  - Flags update only on ADD/SUB; LDA leaves them unchanged.
- ld_en high from any state, including HALT or mid-instruction: the next edge enters LOAD and aborts the current instruction. PC and MAR are cleared to 0. A, flags and sap_out are preserved.
- ld_en low in LOAD: the next edge enters F1 and fetches from address 0.
- HALT is left only by ld_en or reset.

## Timing
- Reset (clr_ low, asynchronous):
  - State = F1.
  - PC, MAR, IR, A = 0.
  - zf, cf = 0.
  - sap_out = 0, out_valid = 0, halted = 0.
- Cycle counts:
  - LDA/ADD/SUB/STA: 4 cycles.
  - JMP/JZ/JC/OUT/NOP: 3 cycles.
  - HLT: 3 cycles, then halted.
- sap_out and out_valid are registered. They are visible in the cycle after E1 of OUT, and out_valid lasts exactly one cycle.
- halted is registered: high from the cycle after E1 of HLT.
- A store followed by a load of the same address returns the stored value, because the write completes at the end of E2 before the next read.
- prog_we in LOAD writes at the edge. prog_we is ignored outside LOAD.
- Simultaneous ld_en and OUT E1: ld_en wins, so there is no out_valid pulse and sap_out is unchanged.

## Test plan
All scenarios use DATA_W=8, ADDR_W=4. Cycle 1 is the first edge after ld_en falls.
- Arithmetic and OUT.
  - Load: LDA 9, ADD A, SUB B, OUT, HLT, with M9=0x10, MA=0x14, MB=0x18.
  - Required: out_valid high only in cycle 16 with sap_out=0x0C; halted from cycle 19; cf=1, zf=0.
- Flags and JZ.
  - Load: LDA 8 (0xFF), ADD 9 (0x01), JZ 5, OUT at 3, HLT at 4, HLT at 5.
  - Required: A=0x00, zf=1, cf=1; jump taken; no out_valid ever; halted set.
- STA, JC and PC wrap.
  - Load: STA F, LDA F, OUT, with program bytes reaching address F.
  - Required: sap_out shows the stored value. Executing NOPs through address 0xF wraps PC to 0x0.
- JC not taken.
  - Program: SUB with A=0x03, M=0x05.
  - Required: A=0xFE, cf=0; the following JC falls through to PC+1.
- Reset mid-instruction.
  - Stimulus: drop clr_ during E2 of ADD.
  - Required: all outputs read 0 immediately; execution restarts at F1 from PC=0; memory contents are unchanged.
- Load during run.
  - Stimulus: raise ld_en during E1 of OUT, write new program, then release.
  - Required: no out_valid pulse; the new program executes from address 0; A and sap_out are retained until overwritten.
